i2c_slave_core: RTL and testbench
=================================

I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop synchronizer stages on scl_i and sda_i (minimum 2).
REQ-002 Parameter STRETCH_EN, default 1, enables SCL stretching while read data is not available.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  0 forces IDLE and releases both lines.
REQ-006 own_addr  in  7  7-bit slave address, sampled during the address byte.
REQ-007 scl_i / sda_i  in  1 each  raw bus pin levels, asynchronous.
REQ-008 scl_oe / sda_oe  out  1 each  1 means pull the line low, 0 means release it (open-drain).
REQ-009 rx_data  out  8  last byte received from the master; held until the next write byte completes.
REQ-010 rx_valid  out  1  one-clk pulse when rx_data updates.
REQ-011 tx_data  in  8  byte to return on a master read.
REQ-012 tx_valid / tx_ready  in / out  1 each  tx byte handshake; a transfer occurs on a clk with both high.
REQ-013 addressed  out  1  high from own-address ACK until STOP, repeated START, or master NACK.
REQ-014 rw  out  1  R/W bit of the current transaction; 1 means read.
REQ-015 start_det / stop_det  out  1 each  one-clk pulses on bus START/STOP, whether or not this slave is addressed.

Function
REQ-016 scl_i and sda_i shall pass through SYNC_STAGES flops, then one further register used for edge detection; edge-to-detect latency is SYNC_STAGES+1 clk.
REQ-017 START shall be detected as synced SDA falling while synced SCL is high; STOP as synced SDA rising while synced SCL is high.
REQ-018 States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, IGNORE.
REQ-019 START in any state, including a repeated START, shall go to ADDR, clear the bit counter, and release sda_oe and scl_oe.
REQ-020 STOP in any state shall go to IDLE and release both lines; addressed clears on the same clk.
REQ-021 Incoming bits shall be shifted MSB first on the synced SCL rising edge.
REQ-022 Slave-driven SDA shall change only on the clk after a synced SCL falling edge is detected.
REQ-023 ADDR: after 8 bits, if bits[7:1]==own_addr, go to ADDR_ACK, set rw=bit0, and set addressed; otherwise go to IGNORE with sda_oe=0.
REQ-024 ADDR_ACK: sda_oe=1 from the next SCL fall until the following SCL fall.
REQ-025 After ADDR_ACK, go to TX_LOAD if rw=1, otherwise RX_BYTE.
REQ-026 RX_BYTE: on the 8th rising edge, rx_data shall load and rx_valid shall pulse on the same clk; then go to RX_ACK.
REQ-027 RX_ACK: the slave always ACKs (sda_oe=1 for one SCL low/high period), then returns to RX_BYTE.
REQ-028 TX_LOAD, entered on SCL fall, tx_valid=1: tx_ready=1 for that clk, the shift register loads, sda_oe=~tx_data[7], and the state goes to TX_BYTE.
REQ-029 TX_LOAD, tx_valid=0, STRETCH_EN=1: scl_oe=1 until tx_valid=1; then load as above and release scl_oe one clk after sda_oe settles.
REQ-030 TX_LOAD, tx_valid=0, STRETCH_EN=0: send 8'hFF with no tx_ready.
REQ-031 TX_BYTE: on each SCL fall present the next bit, sda_oe=~bit.
REQ-032 TX_BYTE: after the 8th fall, release SDA and go to TX_ACK.
REQ-033 TX_ACK: sample SDA on the SCL rise. ACK (0) goes to TX_LOAD; NACK (1) goes to IGNORE and clears addressed.
REQ-034 IGNORE: keep both lines released; leave only on START or STOP.
REQ-035 enable=0 mid-transfer: on the next clk go to IDLE, release both lines, clear addressed; no rx_valid or tx_ready pulses.
REQ-036 General-call and 10-bit addressing are not supported; such bytes lead to IGNORE.
REQ-037 tx_ready shall never be high for more than one clk per byte.
REQ-038 rx_valid and tx_ready shall never be high on the same clk.

Reset
REQ-039 While rst=1: state=IDLE; scl_oe=0, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=0, addressed=0, rw=0, start_det=0, stop_det=0.
REQ-040 While rst=1: synchronizer flops load 1 (idle bus), so no false START is detected after release.
REQ-041 Reset asserted mid-transfer shall release both lines on the first clk edge with rst=1.

Verification
REQ-042 Write: own_addr=7'h2A, master sends 0x54 then 0xA5, 0x3C, STOP. Required: ACK on every byte; rx_valid pulses twice with 0xA5 then 0x3C; stop_det pulses; addressed then low.
REQ-043 Read, tx_valid held high: address 0x55, tx_data sequence 0x81, 0x7E, master NACKs the 2nd byte. Required: master reads 0x81 then 0x7E; tx_ready pulses exactly twice; state IGNORE, then IDLE on STOP.
REQ-044 Stretch: read with tx_valid low for 50 clk after the address ACK. Required: scl_oe=1 for those 50 clk; byte 0x5A is delivered correctly once tx_valid rises.
REQ-045 Address mismatch: master sends 0x66 to own_addr 0x2A, then two data bytes. Required: sda_oe never 1; rx_valid never pulses; addressed stays 0.
REQ-046 Repeated START: write 0x54 then 0x10, repeated START, read 0x55. Required: rx_valid pulses once with 0x10; rw switches to 1; the read is ACKed and returns tx_data.
REQ-047 Disruption: enable=0, or rst=1, asserted during the 4th data bit. Required: both oe outputs 0 on the next clk; no rx_valid; a new transaction after re-enable succeeds.

Source files
------------

// File: rtl/i2c_slave_core.sv
// I2C slave byte engine: synchronised open-drain SCL/SDA, 7-bit addressing,
// byte-wide receive pulse and transmit valid/ready handshake, optional clock stretching.
module i2c_slave_core #(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_EN  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] own_addr,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       addressed,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_q, sda_q;
    logic                   scl_rise, scl_fall, start_evt, stop_evt, last_bit, addr_hit;
    logic [7:0]             sr, rx_data_r;
    logic [2:0]             cnt;
    logic                   sda_oe_r, scl_oe_r, rx_valid_r, addressed_r, rw_r;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_evt = scl_s & sda_q & ~sda_s;
    assign stop_evt  = scl_s & ~sda_q & sda_s;
    assign last_bit  = (cnt == 3'd7);
    // General call (0000000) and 10-bit prefixes (11110xx) never match.
    assign addr_hit  = (sr[6:0] == own_addr) && (sr[6:0] != 7'h00) && (sr[6:3] != 4'b1111);

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable || stop_evt) begin
            state_d = IDLE;
        end else if (start_evt) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR:     if (scl_rise && last_bit) state_d = addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && sda_oe_r) state_d = rw_r ? TX_LOAD : RX_BYTE;
                RX_BYTE:  if (scl_rise && last_bit) state_d = RX_ACK;
                RX_ACK:   if (scl_fall && sda_oe_r) state_d = RX_BYTE;
                TX_LOAD:  if (tx_valid || STRETCH_EN == 0) state_d = TX_BYTE;
                TX_BYTE:  if (scl_fall && last_bit) state_d = TX_ACK;
                TX_ACK: begin
                    if (scl_rise && sda_s) state_d = IGNORE;
                    else if (scl_fall)     state_d = TX_LOAD;
                end
                default:  state_d = state_q;
            endcase
        end
    end

    // Bus-side datapath. Slave-driven SDA only moves on the clk after a detected SCL fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr          <= 8'h00;
            cnt         <= 3'd0;
            sda_oe_r    <= 1'b0;
            scl_oe_r    <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            addressed_r <= 1'b0;
            rw_r        <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (!enable || stop_evt || start_evt) begin
                sda_oe_r    <= 1'b0;
                scl_oe_r    <= 1'b0;
                addressed_r <= 1'b0;
                cnt         <= 3'd0;
            end else begin
                case (state_q)
                    ADDR, RX_BYTE: if (scl_rise) begin
                        sr  <= {sr[6:0], sda_s};
                        cnt <= cnt + 3'd1;
                        if (last_bit && state_q == ADDR && addr_hit) begin
                            addressed_r <= 1'b1;
                            rw_r        <= sda_s;
                        end
                        if (last_bit && state_q == RX_BYTE) begin
                            rx_data_r  <= {sr[6:0], sda_s};
                            rx_valid_r <= 1'b1;
                        end
                    end
                    // First fall drives the ACK low, the next fall releases it.
                    ADDR_ACK, RX_ACK: if (scl_fall) sda_oe_r <= ~sda_oe_r;
                    TX_LOAD: begin
                        cnt <= 3'd0;
                        if (tx_valid) begin
                            sr       <= tx_data;
                            sda_oe_r <= ~tx_data[7];
                        end else if (STRETCH_EN != 0) begin
                            scl_oe_r <= 1'b1;
                        end else begin
                            sr       <= 8'hFF;
                            sda_oe_r <= 1'b0;
                        end
                    end
                    TX_BYTE: begin
                        scl_oe_r <= 1'b0;
                        if (scl_fall) begin
                            cnt <= cnt + 3'd1;
                            if (last_bit) begin
                                sda_oe_r <= 1'b0;
                            end else begin
                                sr       <= {sr[6:0], 1'b1};
                                sda_oe_r <= ~sr[6];
                            end
                        end
                    end
                    TX_ACK: if (scl_rise && sda_s) addressed_r <= 1'b0;
                    default: begin
                        sda_oe_r <= 1'b0;
                        scl_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // tx_valid/tx_ready: a byte moves on any clk where both are high; ready is only offered in TX_LOAD.
    always_comb begin
        tx_ready = 1'b0;
        if (!rst && enable && !start_evt && !stop_evt && state_q == TX_LOAD)
            tx_ready = tx_valid;
        start_det = start_evt & ~rst;
        stop_det  = stop_evt & ~rst;
        scl_oe    = scl_oe_r;
        sda_oe    = sda_oe_r;
        rx_data   = rx_data_r;
        rx_valid  = rx_valid_r;
        addressed = addressed_r;
        rw        = rw_r;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: bit-banged open-drain master, tx byte source,
// bus monitor and rx/read scoreboards.
module tb_i2c_slave_core;
  localparam int Q = 8;
  localparam int LIMIT = 1000;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_IGNORE = 4'd8;

  logic clk, rst, enable;
  logic [6:0] own_addr;
  logic scl_m, sda_m, scl_line, sda_line;
  logic scl_oe, sda_oe, rx_valid, tx_ready, addressed, rw, start_det, stop_det;
  logic [7:0] rx_data, tx_data;
  logic tx_valid;
  logic [3:0] state_dbg;

  logic [7:0] rx_exp_q[$];
  logic [7:0] rx_got_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] tx_src_q[$];
  logic tx_gate;

  int n_tests = 0;
  int n_fail = 0;
  int rxv_cnt = 0, rdy_cnt = 0, start_cnt = 0, stop_cnt = 0, sda_oe_cnt = 0, addr_cnt = 0;
  logic viol_both = 1'b0, viol_rdy2 = 1'b0, rdy_prev = 1'b0;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_core #(.SYNC_STAGES(2), .STRETCH_EN(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .own_addr(own_addr),
    .scl_i(scl_line), .sda_i(sda_line), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .addressed(addressed), .rw(rw),
    .start_det(start_det), .stop_det(stop_det), .state_dbg(state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 200000 clk");
    $fatal(1, "watchdog expired");
  end

  // tx byte source: a transfer seen at a negedge completes on the following posedge
  initial begin
    logic seen;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    forever begin
      @(negedge clk);
      seen = tx_ready;
      @(posedge clk);
      #2;
      if (seen && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
      tx_valid = tx_gate && (tx_src_q.size() > 0);
      tx_data = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    end
  end

  // bus monitor
  always @(negedge clk) begin
    if (rx_valid) rx_got_q.push_back(rx_data);
    if (rx_valid) rxv_cnt++;
    if (tx_ready) rdy_cnt++;
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (sda_oe) sda_oe_cnt++;
    if (addressed) addr_cnt++;
    if (rx_valid && tx_ready) viol_both = 1'b1;
    if (tx_ready && rdy_prev) viol_rdy2 = 1'b1;
    rdy_prev = tx_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_up();
    int t = 0;
    scl_m = 1'b1;
    while (scl_line !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    assert (t < LIMIT) else begin
      n_fail++;
      $error("FAIL scl_wait: waited %0d clk, limit %0d", t, LIMIT);
    end
  endtask

  task automatic start_cond();
    sda_m = 1'b1; q_wait();
    scl_up(); q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; q_wait();
    scl_up(); q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; q_wait();
    scl_up(); q_wait(); q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; q_wait();
    scl_up(); q_wait();
    b = sda_line; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  task automatic drain_rx(input string tag);
    logic [7:0] got, exp;
    check({tag, "_rx_count"}, rx_got_q.size(), rx_exp_q.size());
    while (rx_got_q.size() > 0 && rx_exp_q.size() > 0) begin
      got = rx_got_q.pop_front();
      exp = rx_exp_q.pop_front();
      check({tag, "_rx_byte"}, got, exp);
    end
    rx_got_q.delete();
    rx_exp_q.delete();
  endtask

  initial begin
    logic ack_n, b;
    logic [7:0] d;
    int base_rx, base_rdy, base_stop, base_sda, base_addr, hold;

    rst = 1'b1; enable = 1'b1; own_addr = 7'h2A;
    scl_m = 1'b1; sda_m = 1'b1; tx_gate = 1'b0;

    // reset state
    repeat (4) @(negedge clk);
    check("rst_flags", {scl_oe, sda_oe, rx_valid, tx_ready, addressed, rw, start_det, stop_det}, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_false_start", start_cnt, 0);

    // write 0xA5, 0x3C
    base_rx = rxv_cnt; base_stop = stop_cnt;
    start_cond();
    check("wr_start_pulse", start_cnt, 1);
    write_byte(8'h54, ack_n);
    check("wr_addr_ack", ack_n, 1'b0);
    check("wr_addressed", addressed, 1'b1);
    check("wr_rw", rw, 1'b0);
    rx_exp_q.push_back(8'hA5);
    write_byte(8'hA5, ack_n);
    check("wr_data0_ack", ack_n, 1'b0);
    rx_exp_q.push_back(8'h3C);
    write_byte(8'h3C, ack_n);
    check("wr_data1_ack", ack_n, 1'b0);
    stop_cond();
    check("wr_stop_pulse", stop_cnt - base_stop, 1);
    check("wr_addressed_low", addressed, 1'b0);
    check("wr_rx_pulses", rxv_cnt - base_rx, 2);
    drain_rx("wr");

    // read 0x81, 0x7E with tx_valid already high, NACK on the second
    base_rdy = rdy_cnt;
    tx_src_q.push_back(8'h81); rd_exp_q.push_back(8'h81);
    tx_src_q.push_back(8'h7E); rd_exp_q.push_back(8'h7E);
    tx_gate = 1'b1;
    repeat (4) @(negedge clk);
    start_cond();
    write_byte(8'h55, ack_n);
    check("rd_addr_ack", ack_n, 1'b0);
    check("rd_rw", rw, 1'b1);
    read_byte(d, 1'b0);
    check("rd_byte0", d, rd_exp_q.pop_front());
    read_byte(d, 1'b1);
    check("rd_byte1", d, rd_exp_q.pop_front());
    check("rd_state_ignore", state_dbg, ST_IGNORE);
    check("rd_addressed_low", addressed, 1'b0);
    check("rd_ready_pulses", rdy_cnt - base_rdy, 2);
    stop_cond();
    check("rd_state_idle", state_dbg, ST_IDLE);

    // stretch: tx_valid held low for 50 clk after the address ACK
    tx_gate = 1'b0;
    base_rdy = rdy_cnt;
    tx_src_q.push_back(8'h5A); rd_exp_q.push_back(8'h5A);
    start_cond();
    write_byte(8'h55, ack_n);
    check("st_addr_ack", ack_n, 1'b0);
    hold = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (scl_oe === 1'b1) hold++;
    end
    check("st_scl_held", hold, 50);
    tx_gate = 1'b1;
    read_byte(d, 1'b1);
    check("st_byte", d, rd_exp_q.pop_front());
    check("st_ready_pulses", rdy_cnt - base_rdy, 1);
    stop_cond();

    // address mismatch
    base_rx = rxv_cnt; base_sda = sda_oe_cnt; base_addr = addr_cnt;
    start_cond();
    write_byte(8'h66, ack_n);
    check("mm_addr_nack", ack_n, 1'b1);
    write_byte(8'h11, ack_n);
    write_byte(8'h22, ack_n);
    stop_cond();
    check("mm_sda_oe_never", sda_oe_cnt - base_sda, 0);
    check("mm_rx_never", rxv_cnt - base_rx, 0);
    check("mm_addressed_never", addr_cnt - base_addr, 0);

    // repeated START: write 0x10, then read back
    base_rx = rxv_cnt;
    tx_src_q.push_back(8'hC3); rd_exp_q.push_back(8'hC3);
    start_cond();
    write_byte(8'h54, ack_n);
    rx_exp_q.push_back(8'h10);
    write_byte(8'h10, ack_n);
    check("rs_data_ack", ack_n, 1'b0);
    check("rs_rw_write", rw, 1'b0);
    start_cond();
    write_byte(8'h55, ack_n);
    check("rs_read_ack", ack_n, 1'b0);
    check("rs_rw_read", rw, 1'b1);
    read_byte(d, 1'b1);
    check("rs_read_byte", d, rd_exp_q.pop_front());
    stop_cond();
    check("rs_rx_pulses", rxv_cnt - base_rx, 1);
    drain_rx("rs");

    // enable dropped during the 4th data bit of a write
    base_rx = rxv_cnt;
    start_cond();
    write_byte(8'h54, ack_n);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    sda_m = 1'b0; q_wait();
    scl_up();
    check("en_pre_addressed", addressed, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    check("en_lines_released", {scl_oe, sda_oe}, 2'b00);
    check("en_addressed_clear", addressed, 1'b0);
    check("en_state_idle", state_dbg, ST_IDLE);
    scl_m = 1'b0; q_wait();
    stop_cond();
    enable = 1'b1; q_wait();
    check("en_no_rx", rxv_cnt - base_rx, 0);
    start_cond();
    write_byte(8'h54, ack_n);
    check("en_recover_addr_ack", ack_n, 1'b0);
    rx_exp_q.push_back(8'h99);
    write_byte(8'h99, ack_n);
    stop_cond();
    drain_rx("en");

    // reset asserted during the 4th data bit of a read (slave driving SDA low)
    tx_src_q.push_back(8'hE7);
    start_cond();
    write_byte(8'h55, ack_n);
    read_bit(b); read_bit(b); read_bit(b);
    sda_m = 1'b1; q_wait();
    scl_up();
    check("rs4_pre_sda_drive", sda_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rs4_lines_released", {scl_oe, sda_oe}, 2'b00);
    check("rs4_addressed_rw", {addressed, rw}, 2'b00);
    check("rs4_rx_data", rx_data, 8'h00);
    scl_m = 1'b0; q_wait();
    stop_cond();
    rst = 1'b0; q_wait();
    tx_src_q.push_back(8'h3C); rd_exp_q.push_back(8'h3C);
    start_cond();
    write_byte(8'h55, ack_n);
    check("rs4_recover_ack", ack_n, 1'b0);
    read_byte(d, 1'b1);
    check("rs4_recover_byte", d, rd_exp_q.pop_front());
    stop_cond();

    // global invariants and leftovers
    check("no_rx_tx_same_clk", viol_both, 1'b0);
    check("tx_ready_single_clk", viol_rdy2, 1'b0);
    check("rd_queue_empty", rd_exp_q.size(), 0);
    check("tx_queue_empty", tx_src_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
